// File: rtl/char_display_scan_pkg.sv
// Shared character codes, FSM state type and the character-to-segment decoder
// used by the Morse display scan controller.
package char_display_scan_pkg;

    localparam int CHAR_W = 5;

    localparam logic [CHAR_W-1:0] CHAR_CODE_0     = 5'h00;
    localparam logic [CHAR_W-1:0] CHAR_CODE_F     = 5'h0F;
    // Outside the 0-F hex range so it can never alias a printable digit.
    localparam logic [CHAR_W-1:0] CHAR_CODE_BLANK = 5'h10;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // Segments are {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] char2seg(input logic [CHAR_W-1:0] code);
        logic [6:0] s;
        s = SEG_OFF;
        case (code)
            5'h00: s = 7'h40;
            5'h01: s = 7'h79;
            5'h02: s = 7'h24;
            5'h03: s = 7'h30;
            5'h04: s = 7'h19;
            5'h05: s = 7'h12;
            5'h06: s = 7'h02;
            5'h07: s = 7'h78;
            5'h08: s = 7'h00;
            5'h09: s = 7'h10;
            5'h0A: s = 7'h08;
            5'h0B: s = 7'h03;
            5'h0C: s = 7'h46;
            5'h0D: s = 7'h21;
            5'h0E: s = 7'h06;
            5'h0F: s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/char_display_scan_scan_divider.sv
// Dwell-time divider and digit index for the display scan; the index advances
// once every SCAN_DIV cycles and wraps after the last digit. Never stalls.
module scan_divider #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [$clog2(DIGITS)-1:0] idx_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(DIGITS);

    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap;

    always_comb begin
        wrap  = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d = wrap ? '0 : div_q + DIV_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/char_display_scan.sv
// Scroll buffer + multiplexed 7-segment scan: characters enter at digit 0 and
// shift left; accepts one char per 2 cycles, clear blanks over DIGITS cycles.
module char_display_scan
    import char_display_scan_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHAR_W-1:0]            in_char,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         clear,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic [DIGITS-1:0]            dig_sel,
    output logic [6:0]                   seg
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int IDX_W = $clog2(DIGITS);

    state_e            state_q, state_d;
    logic [CHAR_W-1:0] buf_q [DIGITS];
    logic [CHAR_W-1:0] buf_d [DIGITS];
    logic [CHAR_W-1:0] char_q, char_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [IDX_W-1:0]  scan_idx;

    scan_divider #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .idx_o (scan_idx)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        char_d   = char_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // clear takes priority and suppresses the handshake outright
                in_ready = !clear;
                if (clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (in_valid) begin
                    char_d  = in_char;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = DIGITS - 1; i > 0; i--) begin
                    buf_d[i] = buf_q[i-1];
                end
                buf_d[0] = char_q;
                if (count_q != CNT_W'(DIGITS)) begin
                    count_d = count_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            CLEAR: begin
                buf_d[ptr_q] = CHAR_CODE_BLANK;
                ptr_d        = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DIGITS - 1)) begin
                    ptr_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single decoder shared by all digits; seg and dig_sel come from one idx.
    always_comb begin
        seg_d     = char2seg(buf_q[scan_idx]);
        dig_sel_d = ~(DIGITS'(1) << scan_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int i = 0; i < DIGITS; i++) begin
                buf_q[i] <= CHAR_CODE_BLANK;
            end
            char_q    <= CHAR_CODE_BLANK;
            ptr_q     <= '0;
            count_q   <= '0;
            seg_q     <= SEG_OFF;
            dig_sel_q <= '1;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            char_q    <= char_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign count   = count_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_char_display_scan.sv
// Directed bench: scan frames go through an expected-value queue checked by a
// monitor on each newly lit digit; handshake/count checks are made inline.
module tb_char_display_scan;
    import char_display_scan_pkg::*;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CHAR_W-1:0] in_char;
    logic              in_valid;
    logic              in_ready;
    logic              clear;
    logic [2:0]        count;
    logic [3:0]        dig_sel;
    logic [6:0]        seg;

    always #5 clk = ~clk;

    char_display_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_char  (in_char),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .count    (count),
        .dig_sel  (dig_sel),
        .seg      (seg)
    );

    typedef struct {
        string      name;
        logic [3:0] dsel;
        logic [6:0] seg;
    } frame_t;

    frame_t      exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          accepts = 0;
    logic [3:0]  prev_dsel = 4'hF;
    logic [4:0]  mbuf [4];
    int          mcount;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Hand-written active-low {g..a} patterns for the codes the bench uses.
    function automatic logic [6:0] exp_seg(input logic [4:0] c);
        case (c)
            5'h01: return 7'h79;
            5'h02: return 7'h24;
            5'h03: return 7'h30;
            5'h04: return 7'h19;
            5'h05: return 7'h12;
            5'h0A: return 7'h08;
            default: return 7'h7F;
        endcase
    endfunction

    always @(negedge clk) begin
        frame_t f;
        if (dig_sel != prev_dsel && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            check({f.name, "_dsel"}, 32'(dig_sel), 32'(f.dsel));
            check({f.name, "_seg"}, 32'(seg), 32'(f.seg));
        end
        prev_dsel = dig_sel;
        if (rst_n && in_valid && in_ready) accepts++;
    end

    task automatic model_shift(input logic [4:0] ch);
        for (int i = 3; i > 0; i--) mbuf[i] = mbuf[i-1];
        mbuf[0] = ch;
        if (mcount < 4) mcount++;
    endtask

    task automatic model_blank();
        for (int i = 0; i < 4; i++) mbuf[i] = 5'h10;
        mcount = 0;
    endtask

    task automatic send(input logic [4:0] ch);
        int t;
        t = 0;
        in_char  = ch;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_shift(ch);
    endtask

    task automatic check_frames(input string tag);
        int t;
        repeat (2) @(posedge clk);
        t = 0;
        while (dig_sel != 4'b0111 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            check({tag, "_sync"}, 32'(dig_sel), 32'h7);
            return;
        end
        @(posedge clk);
        exp_q.push_back('{{tag, "_d0"}, 4'hE, exp_seg(mbuf[0])});
        exp_q.push_back('{{tag, "_d1"}, 4'hD, exp_seg(mbuf[1])});
        exp_q.push_back('{{tag, "_d2"}, 4'hB, exp_seg(mbuf[2])});
        exp_q.push_back('{{tag, "_d3"}, 4'h7, exp_seg(mbuf[3])});
        t = 0;
        while (exp_q.size() > 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic rdy [10];
        int   a0;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_char  = '0;
        clear    = 1'b0;
        model_blank();

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dsel", 32'(dig_sel), 32'hF);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_dsel", 32'(dig_sel), 32'hE);
        check("first_seg", 32'(seg), 32'h7F);

        // 2. three characters
        send(5'h01);
        send(5'h02);
        send(5'h03);
        check_frames("t2");
        check("t2_count", 32'(count), 32'd3);

        // 3. overflow: 1 is pushed out
        for (int i = 1; i <= 5; i++) send(5'(i));
        check_frames("t3");
        check("t3_count", 32'(count), 32'd4);

        // 4. in_valid held for 10 cycles
        @(posedge clk);
        #1;
        a0       = accepts;
        in_char  = 5'h0A;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy[i] = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) model_shift(5'h0A);
        check("t4_accepts", 32'(accepts - a0), 32'd5);
        check("t4_rdy0", 32'(rdy[0]), 32'd1);
        check("t4_rdy1", 32'(rdy[1]), 32'd0);
        check("t4_rdy2", 32'(rdy[2]), 32'd1);
        check("t4_rdy3", 32'(rdy[3]), 32'd0);
        check_frames("t4");

        // 5. clear wins over in_valid
        @(posedge clk);
        #1;
        a0       = accepts;
        clear    = 1'b1;
        in_valid = 1'b1;
        in_char  = 5'h07;
        @(negedge clk);
        check("t5_rdy_pulse", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t5_rdy_clr%0d", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("t5_rdy_after", 32'(in_ready), 32'd1);
        check("t5_count", 32'(count), 32'd0);
        check("t5_accepts", 32'(accepts - a0), 32'd0);
        model_blank();
        check_frames("t5");

        // 6. reset while in SHIFT
        send(5'h04);
        send(5'h05);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_dsel", 32'(dig_sel), 32'hF);
        check("t6_seg", 32'(seg), 32'h7F);
        model_blank();
        rst_n = 1'b1;
        check_frames("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
